signed_mult_arb: RTL and testbench

Two-requester round-robin arbiter and sequencer for one shared multi-cycle signed (two's-complement) shift-add multiplier. It accepts N-bit operand pairs from two clients, grants one client at a time, and accumulates one sign-extended partial product per cycle, using a subtract step for the operand MSB. It returns a 2N-bit product tagged with the requester ID. It sits between the operand sources (switch inputs or upstream logic) and the bin2bcd/seven-segment display path.

---
 rtl/signed_mult_pkg.sv | 24 ++
 rtl/signed_mult_arb_if.sv | 38 +++
 rtl/signed_mult_pp.sv | 32 +++
 rtl/signed_mult_arb.sv | 140 ++++++++++++++
 tb/tb_signed_mult_arb.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/signed_mult_pkg.sv
// ============================================================================
// Module  : signed_mult_pkg
// Brief   : Shared types and constants for the signed_mult_arb block.
// Revision: 1.0
// ============================================================================
`default_nettype none

package signed_mult_pkg;

    localparam int DEF_WIDTH = 3;

    localparam logic CLIENT0 = 1'b0;
    localparam logic CLIENT1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        NEG  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/signed_mult_arb_if.sv
// ============================================================================
// Module  : signed_mult_arb_if
// Brief   : Two-client request/grant bus plus the product return path.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface signed_mult_arb_if
    import signed_mult_pkg::*;
#(
    parameter int N = DEF_WIDTH
);
    logic           req0;
    logic [N-1:0]   a0;
    logic [N-1:0]   b0;
    logic           req1;
    logic [N-1:0]   a1;
    logic [N-1:0]   b1;
    logic           gnt0;
    logic           gnt1;
    logic           busy;
    logic           done;
    logic           done_id;
    logic [2*N-1:0] product;

    modport master (
        output req0, a0, b0, req1, a1, b1,
        input  gnt0, gnt1, busy, done, done_id, product
    );

    modport slave (
        input  req0, a0, b0, req1, a1, b1,
        output gnt0, gnt1, busy, done, done_id, product
    );

endinterface

`default_nettype wire

// File: rtl/signed_mult_pp.sv
// ============================================================================
// Module  : signed_mult_pp
// Brief   : Combinational sign-extended, shifted, optionally negated partial product.
// Revision: 1.0
// ============================================================================
`default_nettype none

module signed_mult_pp
    import signed_mult_pkg::*;
#(
    parameter int N = DEF_WIDTH
) (
    input  wire logic [N-1:0]         i_op_a,
    input  wire logic                 i_bit,
    input  wire logic [$clog2(N)-1:0] i_shift,
    input  wire logic                 i_neg,
    output logic      [2*N-1:0]       o_term
);

    logic [N-1:0]   w_masked;
    logic [2*N-1:0] w_ext;
    logic [2*N-1:0] w_signed;

    assign w_masked = i_op_a & {N{i_bit}};
    assign w_ext    = {{N{w_masked[N-1]}}, w_masked};
    // Negate after widening so the most negative operand flips to a positive value
    assign w_signed = i_neg ? (-w_ext) : w_ext;
    assign o_term   = w_signed << i_shift;

endmodule

`default_nettype wire

// File: rtl/signed_mult_arb.sv
// ============================================================================
// Module  : signed_mult_arb
// Brief   : Round-robin arbiter sequencing two clients onto one shift-add signed multiplier.
// Revision: 1.0
// ============================================================================
`default_nettype none

module signed_mult_arb
    import signed_mult_pkg::*;
#(
    parameter int N = DEF_WIDTH
) (
    input  wire logic          clk,
    input  wire logic          rst,
    signed_mult_arb_if.slave   bus
);

    localparam int             CW         = $clog2(N);
    localparam logic [CW-1:0]  C_LAST_ACC = CW'(N - 2);
    localparam logic [CW-1:0]  C_MSB      = CW'(N - 1);

    state_t          r_state,   w_state_nxt;
    logic [2*N-1:0]  r_acc,     w_acc_nxt;
    logic [CW-1:0]   r_cnt,     w_cnt_nxt;
    logic [N-1:0]    r_op_a,    w_op_a_nxt;
    logic [N-1:0]    r_op_b,    w_op_b_nxt;
    logic            r_cur_id,  w_cur_id_nxt;
    logic            r_last_id, w_last_id_nxt;
    logic            r_gnt0,    w_gnt0_nxt;
    logic            r_gnt1,    w_gnt1_nxt;
    logic [2*N-1:0]  r_product, w_product_nxt;

    logic            w_win;
    logic            w_pp_bit;
    logic [CW-1:0]   w_pp_shift;
    logic            w_pp_neg;
    logic [2*N-1:0]  w_pp_term;

    // Client 1 wins when alone, or on a tie when client 0 was served last
    assign w_win = bus.req1 & (~bus.req0 | (r_last_id == CLIENT0));

    signed_mult_pp #(.N(N)) u_pp (
        .i_op_a  (r_op_a),
        .i_bit   (w_pp_bit),
        .i_shift (w_pp_shift),
        .i_neg   (w_pp_neg),
        .o_term  (w_pp_term)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_cur_id  <= CLIENT0;
            r_last_id <= CLIENT1;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_product <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_acc     <= w_acc_nxt;
            r_cnt     <= w_cnt_nxt;
            r_op_a    <= w_op_a_nxt;
            r_op_b    <= w_op_b_nxt;
            r_cur_id  <= w_cur_id_nxt;
            r_last_id <= w_last_id_nxt;
            r_gnt0    <= w_gnt0_nxt;
            r_gnt1    <= w_gnt1_nxt;
            r_product <= w_product_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_acc_nxt     = r_acc;
        w_cnt_nxt     = r_cnt;
        w_op_a_nxt    = r_op_a;
        w_op_b_nxt    = r_op_b;
        w_cur_id_nxt  = r_cur_id;
        w_last_id_nxt = r_last_id;
        w_gnt0_nxt    = 1'b0;
        w_gnt1_nxt    = 1'b0;
        w_product_nxt = r_product;
        w_pp_bit      = 1'b0;
        w_pp_shift    = r_cnt;
        w_pp_neg      = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    w_op_a_nxt    = w_win ? bus.a1 : bus.a0;
                    w_op_b_nxt    = w_win ? bus.b1 : bus.b0;
                    w_cur_id_nxt  = w_win;
                    w_last_id_nxt = w_win;
                    w_gnt0_nxt    = ~w_win;
                    w_gnt1_nxt    = w_win;
                    w_acc_nxt     = '0;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = ACC;
                end
            end
            ACC: begin
                w_pp_bit  = r_op_b[r_cnt];
                w_acc_nxt = r_acc + w_pp_term;
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == C_LAST_ACC) begin
                    w_state_nxt = NEG;
                end
            end
            NEG: begin
                // Operand MSB carries weight -2^(N-1), hence the subtract step
                w_pp_bit      = r_op_b[N-1];
                w_pp_shift    = C_MSB;
                w_pp_neg      = 1'b1;
                w_acc_nxt     = r_acc + w_pp_term;
                w_product_nxt = w_acc_nxt;
                w_state_nxt   = DONE;
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.gnt0    = r_gnt0;
    assign bus.gnt1    = r_gnt1;
    assign bus.busy    = (r_state != IDLE);
    assign bus.done    = (r_state == DONE);
    assign bus.done_id = (r_state == DONE) & r_cur_id;
    assign bus.product = r_product;

endmodule

`default_nettype wire

// File: tb/tb_signed_mult_arb.sv
// ============================================================================
// Module  : tb_signed_mult_arb
// Brief   : Directed vector table plus hand-written sequences for signed_mult_arb.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_signed_mult_arb;

    localparam int N = 3;

    typedef struct {
        logic       id;
        logic [2:0] a;
        logic [2:0] b;
        logic [5:0] exp;
    } vec_t;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    vec_t vecs[8];

    signed_mult_arb_if #(.N(N)) bus ();

    signed_mult_arb #(.N(N)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic id, input logic [2:0] a, input logic [2:0] b);
        if (id == 1'b0) begin
            bus.req0 = 1'b1; bus.a0 = a; bus.b0 = b;
        end else begin
            bus.req1 = 1'b1; bus.a1 = a; bus.b1 = b;
        end
    endtask

    // Waits for done (bounded), checks latency/product/id, then one idle cycle
    task automatic finish_op(input string nm, input logic id, input logic [5:0] exp, input int lat);
        int cyc;
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, " done latency"}, cyc, lat);
        chk({nm, " product"}, {26'd0, bus.product}, {26'd0, exp});
        chk({nm, " done_id"}, {31'd0, bus.done_id}, {31'd0, id});
        @(negedge clk);
        chk({nm, " done one cycle"}, {31'd0, bus.done}, 32'd0);
        chk({nm, " product held"}, {26'd0, bus.product}, {26'd0, exp});
    endtask

    // Issues one request from idle; grant is expected at the first negedge
    task automatic issue(input string nm, input logic id, input logic [2:0] a,
                         input logic [2:0] b, input logic [5:0] exp);
        int   cyc;
        logic got;
        drive(id, a, b);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 30) begin
            @(negedge clk);
            cyc++;
            got = id ? bus.gnt1 : bus.gnt0;
        end
        chk({nm, " grant wait"}, cyc, 1);
        chk({nm, " other gnt low"}, {31'd0, id ? bus.gnt0 : bus.gnt1}, 32'd0);
        chk({nm, " busy with gnt"}, {31'd0, bus.busy}, 32'd1);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        finish_op(nm, id, exp, N);
    endtask

    initial begin
        int          cnt;
        int          ai;
        int          bi;
        logic signed [2:0] sa;
        logic signed [2:0] sb;

        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.req0 = 1'b0; bus.a0 = '0; bus.b0 = '0;
        bus.req1 = 1'b0; bus.a1 = '0; bus.b1 = '0;

        vecs[0] = '{1'b0, 3'b011, 3'b110, 6'b111010};  //  3 * -2 = -6
        vecs[1] = '{1'b0, 3'b100, 3'b100, 6'b010000};  // -4 * -4 = 16
        vecs[2] = '{1'b0, 3'b100, 3'b011, 6'b110100};  // -4 *  3 = -12
        vecs[3] = '{1'b1, 3'b011, 3'b011, 6'b001001};  //  3 *  3 = 9
        vecs[4] = '{1'b1, 3'b111, 3'b100, 6'b000100};  // -1 * -4 = 4
        vecs[5] = '{1'b0, 3'b010, 3'b101, 6'b111010};  //  2 * -3 = -6
        vecs[6] = '{1'b1, 3'b000, 3'b111, 6'b000000};  //  0 * -1 = 0
        vecs[7] = '{1'b1, 3'b011, 3'b100, 6'b110100};  //  3 * -4 = -12

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset gnt0", {31'd0, bus.gnt0}, 32'd0);
        chk("reset gnt1", {31'd0, bus.gnt1}, 32'd0);
        chk("reset done", {31'd0, bus.done}, 32'd0);
        chk("reset done_id", {31'd0, bus.done_id}, 32'd0);
        chk("reset product", {26'd0, bus.product}, 32'd0);
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.busy) cnt++;
        end
        chk("idle busy stays low", cnt, 0);

        // Simultaneous requests straight out of reset: client 0 first
        drive(1'b0, 3'd2, 3'd3);
        drive(1'b1, 3'b111, 3'b111);
        @(negedge clk);
        chk("tie1 gnt0", {31'd0, bus.gnt0}, 32'd1);
        chk("tie1 gnt1", {31'd0, bus.gnt1}, 32'd0);
        bus.req0 = 1'b0;
        cnt = 0;
        for (int k = 0; k < 30 && bus.done !== 1'b1; k++) begin
            @(negedge clk);
            if (bus.gnt1) cnt++;
        end
        chk("pending gnt1 while busy", cnt, 0);
        chk("tie1 product", {26'd0, bus.product}, 32'd6);
        chk("tie1 done_id", {31'd0, bus.done_id}, 32'd0);
        @(negedge clk);
        chk("pending gnt1 in idle cycle", {31'd0, bus.gnt1}, 32'd0);
        @(negedge clk);
        chk("pending gnt1 granted", {31'd0, bus.gnt1}, 32'd1);
        chk("pending gnt0 low", {31'd0, bus.gnt0}, 32'd0);
        bus.req1 = 1'b0;
        finish_op("tie1 client1", 1'b1, 6'b000001, N);

        drive(1'b0, 3'd1, 3'd1);
        drive(1'b1, 3'd2, 3'd2);
        @(negedge clk);
        chk("tie2 gnt0", {31'd0, bus.gnt0}, 32'd1);
        chk("tie2 gnt1", {31'd0, bus.gnt1}, 32'd0);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        finish_op("tie2", 1'b0, 6'b000001, N);

        for (int i = 0; i < 8; i++) begin
            issue($sformatf("vec%0d", i), vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // Reset in the middle of accumulation discards the operation
        drive(1'b0, 3'd3, 3'd3);
        @(negedge clk);
        chk("abort gnt0", {31'd0, bus.gnt0}, 32'd1);
        bus.req0 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", {31'd0, bus.busy}, 32'd0);
        chk("abort done", {31'd0, bus.done}, 32'd0);
        chk("abort product", {26'd0, bus.product}, 32'd0);
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done) cnt++;
        end
        chk("abort no done", cnt, 0);
        issue("after abort", 1'b0, 3'd3, 3'd3, 6'b001001);

        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                sa = 3'(i);
                sb = 3'(j);
                ai = int'(sa);
                bi = int'(sb);
                issue($sformatf("sweep a=%0d b=%0d", ai, bi), 1'((i + j) % 2),
                      3'(i), 3'(j), 6'(ai * bi));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
